seg_scan_driver: RTL

Time-multiplexed multi-digit 7-segment display driver, downstream of the per-digit segment decode. Holds a packed BCD word for NUM_DIGITS digits and scans them one at a time onto a shared segment bus with one-hot digit enables. New display values are double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_bcd_decode.sv | 28 ++
 rtl/seg_scan_driver.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver.
// Segment order is {a,b,c,d,e,f,g}; codes 10..15 are blank.
package seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational BCD to a..g segment lookup.
// Non-decimal codes decode to a dark digit.
module seg_bcd_decode
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [6:0]         seg
);

    // Table lookup; anything above 9 stays blank.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed multi-digit 7-segment scan driver with frame-synchronous update.
// Define SEG_LZ_BLANK_EN to blank leading zero digits (digit 0 never blanked).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          upd_valid,
    output logic                          upd_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] upd_data,
    output logic [6:0]                    seg_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic                          frame_o
);

    localparam int DATA_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DIV_W  = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_W-1:0]     disp;
    logic [DATA_W-1:0]     pending;
    logic                  pending_full;
    logic                  frame_q;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic                  slot_end;
    logic                  frame_end;
    logic                  commit;
    logic                  xfer;
    logic [DIGIT_W-1:0]    cur_digit;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign slot_end  = en && (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign commit    = frame_end && pending_full;
    assign upd_ready = ~pending_full;
    assign xfer      = upd_valid && upd_ready;

    // Slot timer and digit pointer; both freeze while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (en) begin
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Double buffer: accept into pending, swap into disp on a frame edge.
    // A word taken on the frame edge itself waits for the next edge,
    // because pending_full was still clear when that edge was evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp         <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            frame_q <= commit;
            if (commit) begin
                disp         <= pending;
                pending_full <= 1'b0;
            end
            if (xfer) begin
                pending      <= upd_data;
                pending_full <= 1'b1;
            end
        end
    end

    assign cur_digit = disp[int'(idx)*DIGIT_W +: DIGIT_W];

    seg_bcd_decode u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef SEG_LZ_BLANK_EN
    logic [DATA_W-1:0] upper;
    logic              lz_blank;

    // Digit idx and everything above it, shifted down to bit 0.
    assign upper    = disp >> (int'(idx) * DIGIT_W);
    assign lz_blank = (idx != '0) && (upper == '0);
    assign seg_next = lz_blank ? SEG_BLANK : dec_seg;
`else
    assign seg_next = dec_seg;
`endif

    // One-hot anode select for the current digit.
    always_comb begin
        an_next = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_next[k] = (idx == IDX_W'(k));
        end
    end

    // Registered drive; dark while scanning is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            an_q  <= '0;
        end else if (!en) begin
            seg_q <= '0;
            an_q  <= '0;
        end else begin
            seg_q <= seg_next;
            an_q  <= an_next;
        end
    end

    assign seg_o   = seg_q ^ {7{ACTIVE_LOW}};
    assign an_o    = an_q ^ {NUM_DIGITS{ACTIVE_LOW}};
    assign frame_o = frame_q;

endmodule
